redundant_pair_finder: RTL

Upstream stage of the distance calculator in the redundancy controller. Accepts one lowered filter column (up to MAX_C_SIZE weights) over a valid/ready stream, buffers it, then scans all index pairs (idx1 < idx2) and emits each pair whose weights are equal and nonzero. Emitted pairs drive the distance calculator's idx1/idx2 inputs directly; that stage is combinational, so each emitted pair is consumed in its handshake cycle.

---
 rtl/redundant_pair_finder_pkg.sv | 16 +
 rtl/pair_index_iterator.sv | 40 ++++
 rtl/redundant_pair_finder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/redundant_pair_finder_pkg.sv
// Shared definitions for the redundancy controller's pair finder: default
// widths/depths and the scan FSM state encoding.
package redundant_pair_finder_pkg;

    localparam int RPF_WORD_WIDTH = 8;
    localparam int RPF_MAX_C_SIZE = 16;
    localparam int RPF_CNT_WIDTH  = $clog2(RPF_MAX_C_SIZE) + 1;

    typedef enum logic [1:0] {
        RPF_LOAD = 2'd0,
        RPF_SCAN = 2'd1,
        RPF_EMIT = 2'd2,
        RPF_DONE = 2'd3
    } rpf_state_t;

endpackage

// File: rtl/pair_index_iterator.sv
// Walks all index pairs (i < j < n) in lexicographic order and flags the
// final pair (n-2, n-1).
module pair_index_iterator
    import redundant_pair_finder_pkg::*;
#(
    parameter int CNT_WIDTH = RPF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [CNT_WIDTH-1:0] n,
    input  logic                 advance,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] i,
    output logic [CNT_WIDTH-1:0] j,
    output logic                 last_pair
);

    logic [CNT_WIDTH-1:0] n_m1;
    logic [CNT_WIDTH-1:0] n_m2;

    assign n_m1      = n - CNT_WIDTH'(1);
    assign n_m2      = n - CNT_WIDTH'(2);
    assign last_pair = (i == n_m2) && (j == n_m1);

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            i <= '0;
            j <= CNT_WIDTH'(1);
        end else if (advance) begin
            // End of a row: restart j just right of the new i.
            if (j == n_m1) begin
                i <= i + CNT_WIDTH'(1);
                j <= i + CNT_WIDTH'(2);
            end else begin
                j <= j + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/redundant_pair_finder.sv
// Buffers one lowered filter column, then emits every index pair whose
// weights are equal and nonzero, in lexicographic order.
//
//   state | meaning
//   LOAD  | accepting weights into the column buffer
//   SCAN  | comparing buf[i] with buf[j], one pair per cycle
//   EMIT  | holding a matched pair until the distance calculator takes it
//   DONE  | column finished; counters cleared, done pulse follows
module redundant_pair_finder
    import redundant_pair_finder_pkg::*;
#(
    parameter int WORD_WIDTH = RPF_WORD_WIDTH,
    parameter int MAX_C_SIZE = RPF_MAX_C_SIZE,
    parameter int CNT_WIDTH  = RPF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_idx1,
    output logic [WORD_WIDTH-1:0] out_idx2,
    output logic                  done
);

    localparam int IDX_W = $clog2(MAX_C_SIZE);

    rpf_state_t            state, state_nxt;
    logic [WORD_WIDTH-1:0] col_buf [MAX_C_SIZE];
    logic [CNT_WIDTH-1:0]  n, n_nxt;
    logic [CNT_WIDTH-1:0]  i, j;
    logic                  last_pair;
    logic                  advance;
    logic                  clear;
    logic                  beat;
    logic                  match;
    logic                  out_valid_nxt;
    logic                  done_nxt;
    logic [WORD_WIDTH-1:0] idx1_nxt, idx2_nxt;

    pair_index_iterator #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_iter (
        .clk       (clk),
        .reset_n   (reset_n),
        .n         (n),
        .advance   (advance),
        .clear     (clear),
        .i         (i),
        .j         (j),
        .last_pair (last_pair)
    );

    always_comb begin
        state_nxt     = state;
        n_nxt         = n;
        advance       = 1'b0;
        clear         = 1'b0;
        out_valid_nxt = out_valid;
        idx1_nxt      = out_idx1;
        idx2_nxt      = out_idx2;
        in_ready      = (state == RPF_LOAD);
        beat          = in_valid && (state == RPF_LOAD);
        // Pruned (zero) weights are never redundancy candidates.
        match         = (col_buf[i[IDX_W-1:0]] == col_buf[j[IDX_W-1:0]]) &&
                        (col_buf[i[IDX_W-1:0]] != '0);

        unique case (state)
            RPF_LOAD: begin
                if (beat) begin
                    n_nxt = n + CNT_WIDTH'(1);
                    if (in_last || (n == CNT_WIDTH'(MAX_C_SIZE - 1))) begin
                        state_nxt = (n == '0) ? RPF_DONE : RPF_SCAN;
                    end
                end
            end
            RPF_SCAN: begin
                if (match) begin
                    idx1_nxt      = WORD_WIDTH'(i);
                    idx2_nxt      = WORD_WIDTH'(j);
                    out_valid_nxt = 1'b1;
                    state_nxt     = RPF_EMIT;
                end else if (last_pair) begin
                    state_nxt = RPF_DONE;
                end else begin
                    advance = 1'b1;
                end
            end
            RPF_EMIT: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    if (last_pair) begin
                        state_nxt = RPF_DONE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = RPF_SCAN;
                    end
                end
            end
            RPF_DONE: begin
                clear     = 1'b1;
                n_nxt     = '0;
                state_nxt = RPF_LOAD;
            end
            default: state_nxt = RPF_LOAD;
        endcase

        done_nxt = (state == RPF_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= RPF_LOAD;
            n         <= '0;
            out_valid <= 1'b0;
            out_idx1  <= '0;
            out_idx2  <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            n         <= n_nxt;
            out_valid <= out_valid_nxt;
            out_idx1  <= idx1_nxt;
            out_idx2  <= idx2_nxt;
            done      <= done_nxt;
        end
    end

    // No reset needed on the data: n alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (reset_n && beat) begin
            col_buf[n[IDX_W-1:0]] <= in_data;
        end
    end

endmodule
